div_iter: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the EX stage. It executes DIV and DIVU and

---
 rtl/div_iter_pkg.sv | 15 +
 rtl/div_iter.sv | 130 +++++++++++++
 tb/tb_div_iter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// ALU control encodings the datapath decodes into div_iter.start.
package div_iter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // alucontrol encodings for the two divide instructions
   localparam logic [3:0] DIV_CONTROL  = 4'b1010;
   localparam logic [3:0] DIVU_CONTROL = 4'b1011;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV / DIVU) for the EX stage.
// Produces {remainder, quotient} WIDTH+1 cycles after start is accepted.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_div,
   input  logic [WIDTH-1:0]     opa,
   input  logic [WIDTH-1:0]     opb,
   input  logic                 annul,
   output logic                 ready,
   output logic                 busy,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  rem;
   logic [WIDTH-1:0]  quo;
   logic [WIDTH-1:0]  dvs;
   logic              q_neg;
   logic              r_neg;

   logic [WIDTH:0]    shifted;
   logic [WIDTH:0]    diff;
   logic [WIDTH-1:0]  rem_nxt;
   logic [WIDTH-1:0]  quo_nxt;
   logic [WIDTH-1:0]  q_fix;
   logic [WIDTH-1:0]  r_fix;
   logic [WIDTH-1:0]  opa_mag;
   logic [WIDTH-1:0]  opb_mag;
   logic              accept;
   logic              last;

   assign accept  = (state == IDLE) && start && !annul;
   assign last    = (cnt == CW'(WIDTH - 1));
   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign opa_mag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
   assign opb_mag = (signed_div && opb[WIDTH-1]) ? -opb : opb;

   // One restoring step: shift the next dividend bit in, try the subtract.
   // The borrow bit of diff decides whether the subtract is kept.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rem_nxt = '0;
      quo_nxt = '0;
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      if (diff[WIDTH]) begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end
      q_fix = q_neg ? -quo_nxt : quo_nxt;
      r_fix = r_neg ? -rem_nxt : rem_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
                  busy  <= 1'b1;
               end
            end
            BUSY: begin
               if (annul) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
               end
            end
            DONE: begin
               // start is ignored here; the stalled instruction leaves E on this edge
               state <= IDLE;
               ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
      end else if (accept) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= opa_mag;
         dvs    <= opb_mag;
         q_neg  <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]) && (|opb);
         r_neg  <= signed_div && opa[WIDTH-1];
      end else if ((state == BUSY) && !annul) begin
         cnt <= cnt + CW'(1);
         rem <= rem_nxt;
         quo <= quo_nxt;
         if (last) begin
            result <= {r_fix, q_fix};
         end
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scenario tasks drive operations, a
// negedge monitor pops the expected-result queue on every ready pulse.
module tb_div_iter;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic          signed_div;
   logic [W-1:0]  opa;
   logic [W-1:0]  opb;
   logic          annul;
   logic          ready;
   logic          busy;
   logic [2*W-1:0] result;

   int tests;
   int fails;
   int cyc;
   int ready_pulses;
   logic [2*W-1:0] exp_q[$];

   div_iter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .opa        (opa),
      .opb        (opb),
      .annul      (annul),
      .ready      (ready),
      .busy       (busy),
      .result     (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Scoreboard side: every ready pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && ready) begin
         logic [2*W-1:0] e;
         ready_pulses++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ready: result=%h, no result expected", result);
         end else begin
            e = exp_q.pop_front();
            if (result !== e) begin
               fails++;
               $display("FAIL result: got %h, expected %h", result, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {r, q};
   endfunction

   task automatic wait_ready(input int limit, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Issue one op holding start until ready, check latency and pulse width
   task automatic do_op(input string name, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] e);
      int t0;
      bit ok;
      @(negedge clk);
      start      = 1'b1;
      signed_div = sgn;
      opa        = a;
      opb        = b;
      t0         = cyc;
      exp_q.push_back(e);
      wait_ready(LAT + 10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_timeout: ready not seen within %0d cycles", name, LAT + 10);
      end else if (cyc - t0 != LAT) begin
         fails++;
         $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc - t0, LAT);
      end
      start = 1'b0;
      @(negedge clk);
      tests++;
      if (ready !== 1'b0) begin
         fails++;
         $display("FAIL %s_pulse: ready=%b one cycle after DONE, expected 0", name, ready);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      start      = 1'b0;
      signed_div = 1'b0;
      opa        = '0;
      opb        = '0;
      annul      = 1'b0;
      repeat (2) @(negedge clk);
      tests += 3;
      if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, expected 0", ready); end
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      if (result !== '0) begin fails++; $display("FAIL reset_result: got %h, expected 0", result); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      do_op("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14});
      do_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_op("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD});
      do_op("div_m7_m2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3});
   endtask

   task automatic test_boundary();
      do_op("div_min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000});
      do_op("divu_min_m1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0});
      do_op("divu_5_0",    1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF});
      do_op("div_m5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF});
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic          s;
         logic [W-1:0]  a;
         logic [W-1:0]  b;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         do_op("rand", s, a, b, model(s, a, b));
      end
   endtask

   task automatic test_annul();
      logic [2*W-1:0] old;
      old = result;
      @(negedge clk);
      start      = 1'b1;
      signed_div = 1'b0;
      opa        = 32'd1234;
      opb        = 32'd5;
      repeat (10) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL annul_busy_before: got %b, expected 1", busy);
      end
      annul = 1'b1;
      start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      tests += 3;
      if (busy !== 1'b0) begin fails++; $display("FAIL annul_busy: got %b, expected 0", busy); end
      if (ready !== 1'b0) begin fails++; $display("FAIL annul_ready: got %b, expected 0", ready); end
      if (result !== old) begin fails++; $display("FAIL annul_result: got %h, expected %h", result, old); end
      do_op("after_annul", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30});
   endtask

   task automatic test_back_to_back();
      int p0;
      int t1;
      bit ok;
      p0 = ready_pulses;
      @(negedge clk);
      start      = 1'b1;
      signed_div = 1'b0;
      opa        = 32'd1000;
      opb        = 32'd10;
      exp_q.push_back({32'd0, 32'd100});
      wait_ready(LAT + 10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_first_timeout: ready not seen"); end
      // start stays high through DONE; the next instruction appears in E now
      opa = 32'd9;
      opb = 32'd3;
      exp_q.push_back({32'd0, 32'd3});
      t1  = cyc + 1;
      wait_ready(LAT + 10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL b2b_second_timeout: ready not seen");
      end else if (cyc - t1 != LAT) begin
         fails++;
         $display("FAIL b2b_latency: got %0d cycles, expected %0d", cyc - t1, LAT);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (ready_pulses - p0 != 2) begin
         fails++;
         $display("FAIL b2b_pulses: got %0d ready pulses, expected 2", ready_pulses - p0);
      end
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      start      = 1'b1;
      signed_div = 1'b0;
      opa        = 32'd77;
      opb        = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests += 3;
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
      if (ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready: got %b, expected 0", ready); end
      if (result !== '0) begin fails++; $display("FAIL rst_mid_result: got %h, expected 0", result); end
      @(negedge clk);
      rst = 1'b0;
      do_op("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      cyc          = 0;
      ready_pulses = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_random();
      test_annul();
      test_back_to_back();
      test_rst_mid();
      repeat (3) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d results never produced, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
